step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 141 ++++++++++++++
 tb/tb_step_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// Run/pause/single-step controller producing a CPU clock-enable.
// Raw PAUSE/STEP are synchronized and debounced before driving the FSM.

module step_ctrl_db #(
    parameter int DB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_db
);
    localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Counter only advances while the synchronized level disagrees with
    // the debounced one, so any short glitch restarts it from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;
endmodule

module step_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int RUN_DIV   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PAUSE,
    input  logic        STEP,
    output logic        CPU_EN,
    output logic        PAUSED,
    output logic [15:0] STEP_CNT
);
    typedef enum logic [1:0] {S_RUN, S_PAUSED, S_STEP, S_HOLD} state_t;

    localparam logic [15:0] DIV_MAX = 16'(RUN_DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  w_raw;
    logic [1:0]  w_db;
    logic        w_pause_db;
    logic        w_step_db;
    logic        r_step_d;
    logic        w_step_edge;
    logic        w_cpu_en_nxt;
    logic [15:0] r_div;
    logic [15:0] r_step_cnt;
    logic        r_cpu_en;
    logic        r_paused;

    assign w_raw = {STEP, PAUSE};

    for (genvar g = 0; g < 2; g++) begin : g_db
        step_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .i_clk   (CLK),
            .i_rst_n (RST),
            .i_raw   (w_raw[g]),
            .o_db    (w_db[g])
        );
    end

    assign w_pause_db  = w_db[0];
    assign w_step_db   = w_db[1];
    assign w_step_edge = w_step_db & ~r_step_d;

    always_comb begin
        w_next       = r_state;
        w_cpu_en_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_pause_db) w_next = S_PAUSED;
                else            w_cpu_en_nxt = (r_div == DIV_MAX);
            end
            // Releasing PAUSE wins over a coincident step edge.
            S_PAUSED: begin
                if (!w_pause_db)      w_next = S_RUN;
                else if (w_step_edge) w_next = S_STEP;
            end
            S_STEP: begin
                w_next       = S_HOLD;
                w_cpu_en_nxt = 1'b1;
            end
            S_HOLD: begin
                if (!w_pause_db)     w_next = S_RUN;
                else if (!w_step_db) w_next = S_PAUSED;
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_RUN;
            r_step_d   <= 1'b0;
            r_div      <= '0;
            r_step_cnt <= '0;
            r_cpu_en   <= 1'b0;
            r_paused   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_d <= w_step_db;
            r_cpu_en <= w_cpu_en_nxt;
            r_paused <= (w_next != S_RUN);
            // Divider only runs while staying in S_RUN; any other path re-enters at 0.
            if (r_state == S_RUN && !w_pause_db)
                r_div <= (r_div == DIV_MAX) ? 16'd0 : r_div + 16'd1;
            else
                r_div <= '0;
            if (r_state == S_STEP)
                r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    assign CPU_EN   = r_cpu_en;
    assign PAUSED   = r_paused;
    assign STEP_CNT = r_step_cnt;
endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DB_CYCLES=4, RUN_DIV=4.
module tb_step_ctrl;
    logic        CLK;
    logic        RST;
    logic        PAUSE;
    logic        STEP;
    logic        CPU_EN;
    logic        PAUSED;
    logic [15:0] STEP_CNT;

    int n_vec;
    int n_err;

    step_ctrl #(.DB_CYCLES(4), .RUN_DIV(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PAUSE    (PAUSE),
        .STEP     (STEP),
        .CPU_EN   (CPU_EN),
        .PAUSED   (PAUSED),
        .STEP_CNT (STEP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0; PAUSE = 1'b0; STEP = 1'b0;
        repeat (3) tick();
        n_vec++; if (CPU_EN !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en: got %b want 0", CPU_EN); end
        n_vec++; if (PAUSED !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %b want 0", PAUSED); end
        n_vec++; if (STEP_CNT !== 16'h0) begin n_err++; $display("FAIL reset_step_cnt: got %h want 0000", STEP_CNT); end
    endtask

    // Releases reset and checks the 1-in-4 cadence from divider 0.
    task automatic test_run(input string tag);
        int pulses;
        logic exp;
        pulses = 0;
        RST = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp = (k % 4 == 0);
            if (CPU_EN) pulses++;
            n_vec++;
            if (CPU_EN !== exp) begin n_err++; $display("FAIL %s_cadence k=%0d: got %b want %b", tag, k, CPU_EN, exp); end
        end
        n_vec++; if (pulses != 10) begin n_err++; $display("FAIL %s_pulses: got %0d want 10", tag, pulses); end
        n_vec++; if (PAUSED !== 1'b0) begin n_err++; $display("FAIL %s_paused: got %b want 0", tag, PAUSED); end
        n_vec++; if (STEP_CNT !== 16'h0) begin n_err++; $display("FAIL %s_step_cnt: got %h want 0000", tag, STEP_CNT); end
    endtask

    task automatic test_pause_glitch_steps;
        PAUSE = 1'b1;
        repeat (12) tick();
        n_vec++; if (PAUSED !== 1'b1) begin n_err++; $display("FAIL pause_enter: got %b want 1", PAUSED); end
        for (int p = 0; p < 3; p++) begin
            STEP = 1'b1;
            for (int i = 0; i < 13; i++) begin
                if (i == 3) STEP = 1'b0;
                tick();
                n_vec++;
                if (CPU_EN !== 1'b0) begin n_err++; $display("FAIL glitch_cpu_en p=%0d i=%0d: got %b want 0", p, i, CPU_EN); end
            end
        end
        n_vec++; if (STEP_CNT !== 16'h0) begin n_err++; $display("FAIL glitch_step_cnt: got %h want 0000", STEP_CNT); end
        n_vec++; if (PAUSED !== 1'b1) begin n_err++; $display("FAIL glitch_paused: got %b want 1", PAUSED); end
    endtask

    task automatic test_step_hold;
        int pulses;
        int pos;
        for (int ph = 0; ph < 3; ph++) begin
            STEP = (ph != 1);
            pulses = 0; pos = -1;
            for (int i = 1; i <= ((ph == 1) ? 50 : 150); i++) begin
                tick();
                if (CPU_EN) begin pulses++; pos = i; end
            end
            n_vec++;
            if (pulses != ((ph == 1) ? 0 : 1)) begin n_err++; $display("FAIL hold_pulses ph=%0d: got %0d want %0d", ph, pulses, (ph == 1) ? 0 : 1); end
            if (ph != 1) begin
                n_vec++;
                if (pos != 8) begin n_err++; $display("FAIL hold_latency ph=%0d: got %0d want 8", ph, pos); end
            end
        end
        n_vec++; if (STEP_CNT !== 16'd2) begin n_err++; $display("FAIL hold_step_cnt: got %h want 0002", STEP_CNT); end
        n_vec++; if (PAUSED !== 1'b1) begin n_err++; $display("FAIL hold_paused: got %b want 1", PAUSED); end
    endtask

    // In S_HOLD with STEP still down, release PAUSE.
    task automatic test_unpause_held;
        logic exp;
        PAUSE = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 6) begin
                n_vec++; if (PAUSED !== 1'b1) begin n_err++; $display("FAIL unpause_paused_early: got %b want 1", PAUSED); end
            end
            if (i == 7) begin
                n_vec++; if (PAUSED !== 1'b0) begin n_err++; $display("FAIL unpause_paused: got %b want 0", PAUSED); end
            end
            exp = (i >= 11) && ((i - 11) % 4 == 0);
            n_vec++;
            if (CPU_EN !== exp) begin n_err++; $display("FAIL unpause_cadence i=%0d: got %b want %b", i, CPU_EN, exp); end
        end
        n_vec++; if (STEP_CNT !== 16'd2) begin n_err++; $display("FAIL unpause_step_cnt: got %h want 0002", STEP_CNT); end
    endtask

    task automatic test_run_step_ignored;
        int pulses;
        int pos;
        STEP = 1'b0; repeat (10) tick();
        STEP = 1'b1; repeat (20) tick();
        PAUSE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= 7) begin
                n_vec++;
                if (CPU_EN !== 1'b0) begin n_err++; $display("FAIL ignored_cpu_en i=%0d: got %b want 0", i, CPU_EN); end
            end
        end
        n_vec++; if (PAUSED !== 1'b1) begin n_err++; $display("FAIL ignored_paused: got %b want 1", PAUSED); end
        n_vec++; if (STEP_CNT !== 16'd2) begin n_err++; $display("FAIL ignored_step_cnt: got %h want 0002", STEP_CNT); end
        STEP = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (CPU_EN) pulses++; end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL ignored_release_pulses: got %0d want 0", pulses); end
        STEP = 1'b1;
        pulses = 0; pos = -1;
        for (int i = 1; i <= 20; i++) begin tick(); if (CPU_EN) begin pulses++; pos = i; end end
        n_vec++; if (pulses != 1 || pos != 8) begin n_err++; $display("FAIL fresh_step: got %0d pulses at %0d want 1 at 8", pulses, pos); end
        n_vec++; if (STEP_CNT !== 16'd3) begin n_err++; $display("FAIL fresh_step_cnt: got %h want 0003", STEP_CNT); end
        STEP = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset_in_step;
        STEP = 1'b1;
        repeat (7) tick();
        n_vec++; if (CPU_EN !== 1'b0 || PAUSED !== 1'b1) begin n_err++; $display("FAIL pre_reset: got en=%b paused=%b want en=0 paused=1", CPU_EN, PAUSED); end
        RST = 1'b0;
        #1;
        n_vec++; if (CPU_EN !== 1'b0) begin n_err++; $display("FAIL async_cpu_en: got %b want 0", CPU_EN); end
        n_vec++; if (PAUSED !== 1'b0) begin n_err++; $display("FAIL async_paused: got %b want 0", PAUSED); end
        n_vec++; if (STEP_CNT !== 16'h0) begin n_err++; $display("FAIL async_step_cnt: got %h want 0000", STEP_CNT); end
        PAUSE = 1'b0; STEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (CPU_EN !== 1'b0) begin n_err++; $display("FAIL reset_held_cpu_en i=%0d: got %b want 0", i, CPU_EN); end
        end
        test_run("rerun");
    endtask

    task automatic test_wrap;
        int pulses;
        PAUSE = 1'b1;
        repeat (12) tick();
        force dut.r_step_cnt = 16'hFFFF;
        tick();
        release dut.r_step_cnt;
        tick();
        n_vec++; if (STEP_CNT !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", STEP_CNT); end
        STEP = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (CPU_EN) pulses++; end
        n_vec++; if (STEP_CNT !== 16'h0000) begin n_err++; $display("FAIL wrap_step_cnt: got %h want 0000", STEP_CNT); end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL wrap_pulses: got %0d want 1", pulses); end
        STEP = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_run("run");
        test_pause_glitch_steps();
        test_step_hold();
        test_unpause_held();
        test_run_step_ignored();
        test_reset_in_step();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
